// File: rtl/instr_fetch_unit.sv
// Instruction fetch: single-outstanding imem reads buffered with their PC into a small FIFO for decode.
// Optional build macro IFETCH_PERF_CNT_EN adds fetch/flush performance counters.
module instr_fetch_unit #(
    parameter int ADDR_W     = 72,
    parameter int INSTR_W    = 60,
    parameter int FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  pc_in,
    output logic               pc_advance,
    input  logic               redirect,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_resp_valid,
    input  logic [INSTR_W-1:0] imem_resp_data,
    output logic               dec_valid,
    input  logic               dec_ready,
    output logic [INSTR_W-1:0] dec_instr,
    output logic [ADDR_W-1:0]  dec_pc
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0]        perf_fetch_cnt,
    output logic [31:0]        perf_flush_cnt
`endif
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_stale;
    logic               w_stale_nxt;
    logic [ADDR_W-1:0]  r_req_addr;

    logic [ADDR_W-1:0]  r_fifo_pc    [FIFO_DEPTH];
    logic [INSTR_W-1:0] r_fifo_instr [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic               w_issue;
    logic               w_push;
    logic               w_pop;
    logic               w_dec_valid;
    logic               w_req_valid;

    // Issue only when IDLE, so the FIFO count alone already reserves a slot for the fetch.
    always_comb begin
        w_state_nxt = r_state;
        w_stale_nxt = r_stale;
        w_issue     = 1'b0;
        w_push      = 1'b0;
        w_req_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                if ((r_count < DEPTH_C) && !redirect && !reset) begin
                    w_issue     = 1'b1;
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                w_req_valid = 1'b1;
                if (redirect) begin
                    w_stale_nxt = 1'b1;
                end
                if (imem_req_ready) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_resp_valid) begin
                    w_push      = !r_stale && !redirect;
                    w_stale_nxt = 1'b0;
                    w_state_nxt = S_IDLE;
                end else if (redirect) begin
                    w_stale_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_stale    <= 1'b0;
            r_req_addr <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_stale <= w_stale_nxt;
            if (w_issue) begin
                r_req_addr <= pc_in;
            end
        end
    end

    assign w_dec_valid = (r_count != '0);
    assign w_pop       = w_dec_valid && dec_ready && !redirect;

    // Redirect flushes the buffer and wins over any same-cycle push or pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (redirect) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_pc[r_wr_ptr]    <= r_req_addr;
            r_fifo_instr[r_wr_ptr] <= imem_resp_data;
        end
    end

    assign pc_advance     = w_issue;
    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = r_req_addr;
    assign dec_valid      = w_dec_valid;
    // Head is masked while empty so the unreset storage never leaks onto the outputs.
    assign dec_instr      = w_dec_valid ? r_fifo_instr[r_rd_ptr] : '0;
    assign dec_pc         = w_dec_valid ? r_fifo_pc[r_rd_ptr]    : '0;

`ifdef IFETCH_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetch_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (w_push) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (redirect) begin
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: transaction-level fetch model plus randomized memory/decode traffic.
module tb_instr_fetch_unit;

    localparam int ADDR_W  = 72;
    localparam int INSTR_W = 60;
    localparam int DEPTH   = 2;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [ADDR_W-1:0]  pc_in;
    logic               pc_advance;
    logic               redirect;
    logic               imem_req_valid;
    logic               imem_req_ready;
    logic [ADDR_W-1:0]  imem_req_addr;
    logic               imem_resp_valid;
    logic [INSTR_W-1:0] imem_resp_data;
    logic               dec_valid;
    logic               dec_ready;
    logic [INSTR_W-1:0] dec_instr;
    logic [ADDR_W-1:0]  dec_pc;
`ifdef IFETCH_PERF_CNT_EN
    logic [31:0]        perf_fetch_cnt;
    logic [31:0]        perf_flush_cnt;
`endif

    instr_fetch_unit #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk             (clk),
        .reset           (reset),
        .pc_in           (pc_in),
        .pc_advance      (pc_advance),
        .redirect        (redirect),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .dec_valid       (dec_valid),
        .dec_ready       (dec_ready),
        .dec_instr       (dec_instr),
        .dec_pc          (dec_pc)
`ifdef IFETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt  (perf_fetch_cnt),
        .perf_flush_cnt  (perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    entry_t exp_q[$];
    int errors = 0;
    int checks = 0;
    int phase  = 0;

    // Fetch transaction model: 0 = none, 1 = awaiting acceptance, 2 = awaiting response
    int                m_fetch = 0;
    logic              m_live = 1'b0;
    logic [ADDR_W-1:0] m_addr = '0;
    int                resp_wait = -1;
    logic [31:0]       m_fetch_cnt = '0;
    logic [31:0]       m_flush_cnt = '0;

    int sl_adv  = 0;
    int sl_resp = 0;
    int sl_pops = 0;
    int mon_adv = 0;
    int bp_acc  = 0;

    logic [ADDR_W-1:0]  sl_pc  [3];
    logic [INSTR_W-1:0] sl_ins [3];

    task automatic check_eq(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [ADDR_W-1:0] rnd_addr();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[ADDR_W-1:0];
    endfunction

    function automatic logic [INSTR_W-1:0] rnd_data();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[INSTR_W-1:0];
    endfunction

    // Monitor: compares DUT outputs against the scoreboard state at the start of each cycle
    always @(negedge clk) begin
        if (reset) begin
            check_eq("rst_pc_advance", pc_advance, 1'b0);
            check_eq("rst_req_valid", imem_req_valid, 1'b0);
            check_eq("rst_req_addr", imem_req_addr, '0);
            check_eq("rst_dec_valid", dec_valid, 1'b0);
            check_eq("rst_dec_pc", dec_pc, '0);
            check_eq("rst_dec_instr", dec_instr, '0);
`ifdef IFETCH_PERF_CNT_EN
            check_eq("rst_perf_fetch", perf_fetch_cnt, '0);
            check_eq("rst_perf_flush", perf_flush_cnt, '0);
`endif
        end else begin
            check_eq("pc_advance", pc_advance,
                     (m_fetch == 0) && (exp_q.size() < DEPTH) && !redirect);
            check_eq("req_valid", imem_req_valid, m_fetch == 1);
            if (m_fetch == 1) check_eq("req_addr", imem_req_addr, m_addr);
            check_eq("dec_valid", dec_valid, exp_q.size() > 0);
            if (exp_q.size() > 0) begin
                check_eq("dec_pc", dec_pc, exp_q[0].pc);
                check_eq("dec_instr", dec_instr, exp_q[0].instr);
                if (dec_ready && !redirect && phase == 0 && sl_pops < 3) begin
                    check_eq("line_pc", dec_pc, sl_pc[sl_pops]);
                    check_eq("line_instr", dec_instr, sl_ins[sl_pops]);
                    sl_pops++;
                end
            end
            if (pc_advance) mon_adv++;
            if (phase == 1 && imem_req_valid && imem_req_ready) bp_acc++;
`ifdef IFETCH_PERF_CNT_EN
            check_eq("perf_fetch", perf_fetch_cnt, m_fetch_cnt);
            check_eq("perf_flush", perf_flush_cnt, m_flush_cnt);
`endif
        end
    end

    // Applies the cycle that just ended (inputs still hold their values at this edge)
    task automatic model_update();
        logic   adv, pop, push;
        entry_t e;
        adv  = (m_fetch == 0) && (exp_q.size() < DEPTH) && !redirect;
        pop  = (exp_q.size() > 0) && dec_ready && !redirect;
        push = 1'b0;
        e    = '0;
        if (m_fetch == 1) begin
            if (redirect) m_live = 1'b0;
            if (imem_req_ready) begin
                m_fetch   = 2;
                resp_wait = (phase == 0) ? 1 : int'($urandom_range(1, 3));
            end
        end else if (m_fetch == 2) begin
            if (imem_resp_valid) begin
                push    = m_live && !redirect;
                e.pc    = m_addr;
                e.instr = imem_resp_data;
                m_fetch = 0;
            end else if (redirect) begin
                m_live = 1'b0;
            end
        end
        if (adv) begin
            m_fetch = 1;
            m_addr  = pc_in;
            m_live  = 1'b1;
            sl_adv++;
        end
        if (redirect) begin
            exp_q.delete();
            m_flush_cnt++;
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (push) begin
                exp_q.push_back(e);
                m_fetch_cnt++;
            end
        end
    endtask

    task automatic drive_inputs();
        imem_resp_valid = 1'b0;
        imem_resp_data  = rnd_data();
        if (resp_wait > 0) begin
            resp_wait--;
            if (resp_wait == 0) begin
                imem_resp_valid = 1'b1;
                resp_wait       = -1;
            end
        end
        case (phase)
            0: begin
                redirect       = 1'b0;
                imem_req_ready = 1'b1;
                dec_ready      = 1'b1;
                pc_in          = ADDR_W'(72 * sl_adv);
                if (imem_resp_valid) begin
                    imem_resp_data = INSTR_W'(10 + sl_resp);
                    sl_resp++;
                end
            end
            1: begin
                redirect       = 1'b0;
                imem_req_ready = 1'b1;
                dec_ready      = 1'b0;
                pc_in          = rnd_addr();
            end
            default: begin
                redirect       = ($urandom_range(0, 9) == 0);
                imem_req_ready = ($urandom_range(0, 2) != 0);
                dec_ready      = ($urandom_range(0, 4) < 2);
                pc_in          = rnd_addr();
            end
        endcase
    endtask

    task automatic run_cycle();
        @(posedge clk);
        model_update();
        #1;
        drive_inputs();
    endtask

    task automatic do_reset();
        reset           = 1'b1;
        exp_q.delete();
        m_fetch         = 0;
        m_live          = 1'b0;
        resp_wait       = -1;
        m_fetch_cnt     = '0;
        m_flush_cnt     = '0;
        redirect        = 1'b0;
        imem_resp_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        sl_pc[0]  = 72'd0;
        sl_pc[1]  = 72'd72;
        sl_pc[2]  = 72'd144;
        sl_ins[0] = 60'hA;
        sl_ins[1] = 60'hB;
        sl_ins[2] = 60'hC;
        pc_in           = '0;
        redirect        = 1'b0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        dec_ready       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        phase = 0;
        drive_inputs();

        // Straight-line fetch of 0, 72, 144 with single-cycle memory
        repeat (9) run_cycle();
        check_eq("line_adv_count", mon_adv, 3);
        repeat (1) run_cycle();
        check_eq("line_pop_count", sl_pops, 3);

        // Decode backpressure: only FIFO_DEPTH fetches may be accepted
        phase = 1;
        repeat (20) run_cycle();
        check_eq("bp_accepts", bp_acc, DEPTH);
        check_eq("bp_dec_valid", dec_valid, 1'b1);

        // Randomized traffic with redirects, request stalls and a mid-run reset
        phase = 2;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            model_update();
            #1;
            if (c == 1500) do_reset();
            drive_inputs();
        end
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
